// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with an IF/ID pipeline register.
// Handles a variable-latency instruction memory, hazard-unit stalls,
// redirects and IF/ID flushes.
//
// Optional build macro: FETCH_ALIGN_CHK_EN
//   defined   -> a misaligned fetch PC enters FAULT instead of requesting
//                memory. IF/ID then receives a single NOP marked
//                IFIDValid=1/IFIDFault=1, followed by bubbles.
//   undefined -> no alignment check, no FAULT state, IFIDFault tied 0,
//                and IMAddr carries PC[1:0] unchanged.
//
// Memory handshake: IMReq is held high with a stable IMAddr until IMAck.
// IMAck may arrive in the same cycle IMReq rises. IMAck is ignored while
// IMReq is low. IMRdata is only sampled in the cycle where IMReq=1 and
// IMAck=1. Dropping IMReq, for example at reset, abandons the request.
//
// FetchBusy depends only on state and IMAck, never on PCWr or IFIDWr, so
// the hazard unit can use it without creating a combinational loop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWr,
  input  logic        IFIDWr,
  input  logic        IFIDRst,
  input  logic        NPCSel,
  input  logic [31:0] NPC,
  output logic        IMReq,
  output logic [31:0] IMAddr,
  input  logic        IMAck,
  input  logic [31:0] IMRdata,
  output logic [31:0] IFIDIns,
  output logic [31:0] IFIDPC,
  output logic [31:0] IFIDPCPLUS4,
  output logic        IFIDValid,
  output logic        IFIDFault,
  output logic        FetchBusy,
  output logic [1:0]  dbg_state_o
);

`ifdef FETCH_ALIGN_CHK_EN
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2,
    S_FAULT = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] imaddr_q, imaddr_d;
  logic        req_en_q;
  logic [31:0] hold_ins_q, hold_ins_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] ifid_ins_q, ifid_ins_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pcp4_q, ifid_pcp4_d;
  logic        ifid_valid_q, ifid_valid_d;
`ifdef FETCH_ALIGN_CHK_EN
  logic        ifid_fault_q, ifid_fault_d;
  logic        fault_mark_q, fault_mark_d;
`endif

  logic        redirect;
  logic        ack;
  logic        word_rdy;
  logic [31:0] word_ins;
  logic [31:0] word_pc;
  logic        new_req;

  // A request is outstanding in FETCH (live) and in DROP (stale).
  // req_en_q keeps IMReq low until the first clock edge after reset is released.
  assign IMReq    = req_en_q & ((state_q == S_FETCH) | (state_q == S_DROP));
  assign ack      = IMAck & IMReq;
  assign redirect = NPCSel & PCWr;
  assign word_rdy = ((state_q == S_FETCH) & ack) | (state_q == S_HOLD);
  assign word_ins = (state_q == S_HOLD) ? hold_ins_q : IMRdata;
  assign word_pc  = (state_q == S_HOLD) ? hold_pc_q : pc_q;

  assign FetchBusy   = ~word_rdy;
  assign IMAddr      = imaddr_q;
  assign IFIDIns     = ifid_ins_q;
  assign IFIDPC      = ifid_pc_q;
  assign IFIDPCPLUS4 = ifid_pcp4_q;
  assign IFIDValid   = ifid_valid_q;
  assign dbg_state_o = state_q;
`ifdef FETCH_ALIGN_CHK_EN
  assign IFIDFault   = ifid_fault_q;
`else
  assign IFIDFault   = 1'b0;
`endif

  // Next-state, PC, hold buffer and IF/ID load decisions.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imaddr_d    = imaddr_q;
    hold_ins_d  = hold_ins_q;
    hold_pc_d   = hold_pc_q;
    ifid_ins_d  = ifid_ins_q;
    ifid_pc_d   = ifid_pc_q;
    ifid_pcp4_d = ifid_pcp4_q;
    ifid_valid_d = ifid_valid_q;
`ifdef FETCH_ALIGN_CHK_EN
    ifid_fault_d = ifid_fault_q;
    fault_mark_d = fault_mark_q;
`endif
    new_req = 1'b0;

    // IF/ID: flush wins. A word is loaded only if it is not being discarded by a redirect.
    if (IFIDRst) begin
      ifid_ins_d   = NOP_INS;
      ifid_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      ifid_fault_d = 1'b0;
`endif
    end else if (IFIDWr) begin
      if (word_rdy && !redirect) begin
        ifid_ins_d   = word_ins;
        ifid_pc_d    = word_pc;
        ifid_pcp4_d  = word_pc + 32'd4;
        ifid_valid_d = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
        ifid_fault_d = 1'b0;
`endif
      end else begin
        ifid_ins_d   = NOP_INS;
        ifid_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        ifid_fault_d = 1'b0;
        // The first load after entering FAULT carries the fault marker.
        if (state_q == S_FAULT) begin
          ifid_valid_d = fault_mark_q;
          ifid_fault_d = fault_mark_q;
          ifid_pc_d    = pc_q;
          ifid_pcp4_d  = pc_q + 32'd4;
          fault_mark_d = 1'b0;
        end
`endif
      end
    end

    case (state_q)
      S_FETCH: begin
        if (ack) begin
          if (redirect) begin
            pc_d    = NPC;
            new_req = 1'b1;
          end else if (IFIDWr || IFIDRst) begin
            if (PCWr) pc_d = pc_q + 32'd4;
            new_req = 1'b1;
          end else begin
            hold_ins_d = IMRdata;
            hold_pc_d  = pc_q;
            state_d    = S_HOLD;
          end
        end else if (redirect) begin
          // The old request must still complete; its data is thrown away.
          pc_d    = NPC;
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = NPC;
          new_req = 1'b1;
        end else if (IFIDWr || IFIDRst) begin
          pc_d    = pc_q + 32'd4;
          new_req = 1'b1;
        end
      end
      S_DROP: begin
        if (redirect) pc_d = NPC;
        if (ack) new_req = 1'b1;
      end
`ifdef FETCH_ALIGN_CHK_EN
      S_FAULT: begin
        if (redirect) begin
          pc_d    = NPC;
          new_req = 1'b1;
        end
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Every new request latches its address from the next PC.
    if (new_req) begin
      state_d  = S_FETCH;
      imaddr_d = pc_d;
`ifdef FETCH_ALIGN_CHK_EN
      fault_mark_d = 1'b0;
      if (pc_d[1:0] != 2'b00) begin
        state_d      = S_FAULT;
        fault_mark_d = 1'b1;
      end
`endif
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      imaddr_q     <= RESET_PC;
      req_en_q     <= 1'b0;
      hold_ins_q   <= 32'd0;
      hold_pc_q    <= 32'd0;
      ifid_ins_q   <= NOP_INS;
      ifid_pc_q    <= 32'd0;
      ifid_pcp4_q  <= 32'd0;
      ifid_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      ifid_fault_q <= 1'b0;
      fault_mark_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imaddr_q     <= imaddr_d;
      req_en_q     <= 1'b1;
      hold_ins_q   <= hold_ins_d;
      hold_pc_q    <= hold_pc_d;
      ifid_ins_q   <= ifid_ins_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pcp4_q  <= ifid_pcp4_d;
      ifid_valid_q <= ifid_valid_d;
`ifdef FETCH_ALIGN_CHK_EN
      ifid_fault_q <= ifid_fault_d;
      fault_mark_q <= fault_mark_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand-written corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        PCWr, IFIDWr, IFIDRst, NPCSel;
  logic [31:0] NPC;
  logic        IMReq;
  logic [31:0] IMAddr;
  logic        IMAck;
  logic [31:0] IMRdata;
  logic [31:0] IFIDIns, IFIDPC, IFIDPCPLUS4;
  logic        IFIDValid, IFIDFault, FetchBusy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .PCWr(PCWr), .IFIDWr(IFIDWr), .IFIDRst(IFIDRst),
    .NPCSel(NPCSel), .NPC(NPC), .IMReq(IMReq), .IMAddr(IMAddr),
    .IMAck(IMAck), .IMRdata(IMRdata), .IFIDIns(IFIDIns), .IFIDPC(IFIDPC),
    .IFIDPCPLUS4(IFIDPCPLUS4), .IFIDValid(IFIDValid), .IFIDFault(IFIDFault),
    .FetchBusy(FetchBusy), .dbg_state_o(dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pcwr, input logic ifidwr, input logic ifidrst,
                       input logic npcsel, input logic [31:0] npc,
                       input logic ack, input logic [31:0] rdata);
    PCWr = pcwr; IFIDWr = ifidwr; IFIDRst = ifidrst; NPCSel = npcsel;
    NPC = npc; IMAck = ack; IMRdata = rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst imreq", IMReq, 1'b0);
    chk("rst imaddr", IMAddr, 32'h3000);
    chk("rst ins", IFIDIns, NOP);
    chk("rst pc", IFIDPC, 32'd0);
    chk("rst pcp4", IFIDPCPLUS4, 32'd0);
    chk("rst valid", IFIDValid, 1'b0);
    chk("rst fault", IFIDFault, 1'b0);
    chk("rst state", dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release imreq low", IMReq, 1'b0);
    @(posedge clk);
    #1;
    chk("first req", IMReq, 1'b1);
    chk("first addr", IMAddr, 32'h3000);
  endtask

  // One directed cycle: inputs, expected request-side outputs during the
  // cycle, and expected IF/ID contents after the clock edge.
  typedef struct {
    logic        pcwr, ifidwr, ifidrst, npcsel;
    logic [31:0] npc;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pcwr, input logic ifidwr, input logic ifidrst,
                     input logic npcsel, input logic [31:0] npc, input logic ack,
                     input logic e_req, input logic [31:0] e_addr, input logic e_busy,
                     input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.pcwr = pcwr; v.ifidwr = ifidwr; v.ifidrst = ifidrst; v.npcsel = npcsel;
    v.npc = npc; v.ack = ack; v.e_req = e_req; v.e_addr = e_addr;
    v.e_busy = e_busy; v.e_valid = e_valid; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  // Reference model: PC, one memory request (live or stale), a buffer queue
  // of fetched-but-unconsumed words, and a faulted flag.
  typedef struct packed { logic [31:0] ins; logic [31:0] pc; } word_t;
  word_t       m_buf_q[$];
  logic [31:0] m_pc, m_req_addr;
  logic        m_req_on, m_stale, m_faulted, m_mark;
  logic [31:0] m_ins, m_ifpc, m_ifp4;
  logic        m_valid, m_flt;

  task automatic model_init();
    m_buf_q.delete();
    m_pc = 32'h3000; m_req_addr = 32'h3000; m_req_on = 1'b1; m_stale = 1'b0;
    m_faulted = 1'b0; m_mark = 1'b0;
    m_ins = NOP; m_ifpc = 32'd0; m_ifp4 = 32'd0; m_valid = 1'b0; m_flt = 1'b0;
  endtask

  task automatic model_step(input logic pcwr, input logic ifidwr, input logic ifidrst,
                            input logic npcsel, input logic [31:0] npc,
                            input logic ack, input logic [31:0] rdata);
    logic redir, got, start;
    word_t w;
    redir = npcsel & pcwr;
    got = 1'b0; start = 1'b0; w = '0;
    if (m_buf_q.size() != 0) begin
      w = m_buf_q[0]; got = 1'b1;
    end else if (m_req_on && !m_stale && ack) begin
      w.ins = rdata; w.pc = m_req_addr; got = 1'b1;
    end
    if (ifidrst) begin
      m_ins = NOP; m_valid = 1'b0; m_flt = 1'b0;
    end else if (ifidwr) begin
      if (got && !redir) begin
        m_ins = w.ins; m_ifpc = w.pc; m_ifp4 = w.pc + 32'd4; m_valid = 1'b1; m_flt = 1'b0;
      end else if (m_faulted) begin
        m_ins = NOP; m_valid = m_mark; m_flt = m_mark;
        m_ifpc = m_pc; m_ifp4 = m_pc + 32'd4; m_mark = 1'b0;
      end else begin
        m_ins = NOP; m_valid = 1'b0; m_flt = 1'b0;
      end
    end
    if (m_buf_q.size() != 0) begin
      if (redir) begin m_buf_q.delete(); m_pc = npc; start = 1'b1; end
      else if (ifidwr || ifidrst) begin m_buf_q.delete(); m_pc = m_pc + 32'd4; start = 1'b1; end
    end else if (m_faulted) begin
      if (redir) begin m_pc = npc; start = 1'b1; end
    end else if (m_stale) begin
      if (redir) m_pc = npc;
      if (ack) start = 1'b1;
    end else if (ack) begin
      if (redir) begin m_pc = npc; start = 1'b1; end
      else if (ifidwr || ifidrst) begin
        if (pcwr) m_pc = m_pc + 32'd4;
        start = 1'b1;
      end else begin
        m_buf_q.push_back(w); m_req_on = 1'b0;
      end
    end else if (redir) begin
      m_stale = 1'b1; m_pc = npc;
    end
    if (start) begin
      m_req_on = 1'b1; m_stale = 1'b0; m_faulted = 1'b0; m_mark = 1'b0; m_req_addr = m_pc;
`ifdef FETCH_ALIGN_CHK_EN
      if (m_pc[1:0] != 2'b00) begin
        m_req_on = 1'b0; m_faulted = 1'b1; m_mark = 1'b1;
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    //   pcwr ifidwr rst npcsel npc            ack | req addr          busy valid pc
    add(1, 1, 0, 0, 32'h0,         1,   1, 32'h3000,      0, 1, 32'h3000);
    add(1, 1, 0, 0, 32'h0,         1,   1, 32'h3004,      0, 1, 32'h3004);
    add(1, 1, 0, 1, 32'h3100,      0,   1, 32'h3008,      1, 0, 32'h0);
    add(1, 1, 0, 0, 32'h0,         0,   1, 32'h3008,      1, 0, 32'h0);
    add(1, 1, 0, 0, 32'h0,         1,   1, 32'h3008,      1, 0, 32'h0);
    add(1, 1, 0, 0, 32'h0,         1,   1, 32'h3100,      0, 1, 32'h3100);
    add(1, 1, 0, 0, 32'h0,         0,   1, 32'h3104,      1, 0, 32'h0);
    add(1, 1, 0, 0, 32'h0,         0,   1, 32'h3104,      1, 0, 32'h0);
    add(1, 1, 0, 0, 32'h0,         1,   1, 32'h3104,      0, 1, 32'h3104);
    add(0, 0, 0, 0, 32'h0,         1,   1, 32'h3108,      0, 1, 32'h3104);
    add(0, 0, 0, 0, 32'h0,         0,   0, 32'h3108,      0, 1, 32'h3104);
    add(0, 0, 0, 0, 32'h0,         0,   0, 32'h3108,      0, 1, 32'h3104);
    add(1, 1, 0, 0, 32'h0,         0,   0, 32'h3108,      0, 1, 32'h3108);
    add(1, 1, 1, 1, 32'h3200,      1,   1, 32'h310C,      0, 0, 32'h0);
    add(1, 1, 0, 0, 32'h0,         1,   1, 32'h3200,      0, 1, 32'h3200);
    add(1, 1, 0, 0, 32'h0,         1,   1, 32'h3204,      0, 1, 32'h3204);
    add(0, 1, 0, 1, 32'h3300,      1,   1, 32'h3208,      0, 1, 32'h3208);
    add(1, 1, 0, 0, 32'h0,         1,   1, 32'h3208,      0, 1, 32'h3208);
    add(1, 1, 0, 0, 32'h0,         1,   1, 32'h320C,      0, 1, 32'h320C);
    add(1, 0, 0, 0, 32'h0,         1,   1, 32'h3210,      0, 1, 32'h320C);
    add(1, 0, 0, 1, 32'h3400,      0,   0, 32'h3210,      0, 1, 32'h320C);
    add(1, 1, 0, 0, 32'h0,         1,   1, 32'h3400,      0, 1, 32'h3400);
    add(1, 1, 0, 1, 32'hFFFF_FFFC, 1,   1, 32'h3404,      0, 0, 32'h0);
    add(1, 1, 0, 0, 32'h0,         1,   1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC);
    add(1, 1, 0, 0, 32'h0,         1,   1, 32'h0000_0000, 0, 1, 32'h0000_0000);

    do_reset();

    // Directed vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].pcwr, vecs[i].ifidwr, vecs[i].ifidrst, vecs[i].npcsel,
            vecs[i].npc, vecs[i].ack, mem_word(vecs[i].e_addr));
      #1;
      chk($sformatf("vec%0d imreq", i), IMReq, vecs[i].e_req);
      chk($sformatf("vec%0d imaddr", i), IMAddr, vecs[i].e_addr);
      chk($sformatf("vec%0d busy", i), FetchBusy, vecs[i].e_busy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d valid", i), IFIDValid, vecs[i].e_valid);
      chk($sformatf("vec%0d ins", i), IFIDIns,
          vecs[i].e_valid ? mem_word(vecs[i].e_pc) : NOP);
      chk($sformatf("vec%0d fault", i), IFIDFault, 1'b0);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d pc", i), IFIDPC, vecs[i].e_pc);
        chk($sformatf("vec%0d pcp4", i), IFIDPCPLUS4, vecs[i].e_pc + 32'd4);
      end
    end

    // Misaligned redirect; the fetch PC is 0x4 at this point.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h3102, 1'b1, mem_word(32'h4));
    @(posedge clk); #1;
    chk("mis redirect valid", IFIDValid, 1'b0);
`ifdef FETCH_ALIGN_CHK_EN
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    chk("fault imreq", IMReq, 1'b0);
    chk("fault busy", FetchBusy, 1'b1);
    @(posedge clk); #1;
    chk("fault marker valid", IFIDValid, 1'b1);
    chk("fault marker flag", IFIDFault, 1'b1);
    chk("fault marker ins", IFIDIns, NOP);
    @(negedge clk); #1;
    chk("fault imreq 2", IMReq, 1'b0);
    @(posedge clk); #1;
    chk("fault bubble valid", IFIDValid, 1'b0);
    chk("fault bubble flag", IFIDFault, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h3104, 1'b0, 32'd0);
    #1;
    chk("fault exit imreq", IMReq, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, mem_word(32'h3104));
    #1;
    chk("resume imreq", IMReq, 1'b1);
    chk("resume imaddr", IMAddr, 32'h3104);
    @(posedge clk); #1;
    chk("resume valid", IFIDValid, 1'b1);
    chk("resume pc", IFIDPC, 32'h3104);
    chk("resume fault", IFIDFault, 1'b0);
`else
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, mem_word(32'h3102));
    #1;
    chk("mis imreq", IMReq, 1'b1);
    chk("mis imaddr", IMAddr, 32'h3102);
    @(posedge clk); #1;
    chk("mis valid", IFIDValid, 1'b1);
    chk("mis pc", IFIDPC, 32'h3102);
    chk("mis fault", IFIDFault, 1'b0);
`endif

    // Reset while a request is outstanding.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(posedge clk); #1;
    do_reset();

    // Randomized traffic against the reference model.
    model_init();
    for (int c = 0; c < 4000; c++) begin
      logic        pcwr, ifidwr, ifidrst, npcsel, ack, e_busy;
      logic [31:0] npc, rdata;
      @(negedge clk);
      pcwr    = (($urandom_range(0, 9)) != 0);
      ifidwr  = (($urandom_range(0, 9)) > 1);
      ifidrst = (($urandom_range(0, 19)) == 0);
      npcsel  = (($urandom_range(0, 11)) == 0);
      npc     = 32'h3000 + (32'($urandom_range(0, 1023)) << 2);
      if ($urandom_range(0, 7) == 0) npc = npc | 32'($urandom_range(1, 3));
      ack     = m_req_on ? ($urandom_range(0, 2) != 0) : 1'b0;
      rdata   = m_req_on ? mem_word(m_req_addr) : $urandom;
      e_busy  = !((m_req_on && !m_stale && ack) || (m_buf_q.size() != 0));
      drive(pcwr, ifidwr, ifidrst, npcsel, npc, ack, rdata);
      #1;
      chk($sformatf("rnd%0d imreq", c), IMReq, m_req_on);
      if (m_req_on) chk($sformatf("rnd%0d imaddr", c), IMAddr, m_req_addr);
      chk($sformatf("rnd%0d busy", c), FetchBusy, e_busy);
      model_step(pcwr, ifidwr, ifidrst, npcsel, npc, ack, rdata);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d valid", c), IFIDValid, m_valid);
      chk($sformatf("rnd%0d fault", c), IFIDFault, m_flt);
      chk($sformatf("rnd%0d ins", c), IFIDIns, m_ins);
      if (m_valid) begin
        chk($sformatf("rnd%0d pc", c), IFIDPC, m_ifpc);
        chk($sformatf("rnd%0d pcp4", c), IFIDPCPLUS4, m_ifp4);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter NOP_INS, 32'h0000_0000, instruction word inserted for bubbles and flushes.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous active-low reset.
REQ-005 PCWr  in  1  PC write enable from the hazard unit; 0 = stall PC.
REQ-006 IFIDWr  in  1  IF/ID write enable from the hazard unit; 0 = hold IF/ID.
REQ-007 IFIDRst  in  1  IF/ID flush; loads NOP_INS, IFIDValid=0.
REQ-008 NPCSel  in  1  redirect request from the NPC logic.
REQ-009 NPC  in  32  redirect target.
REQ-010 IMReq  out  1  instruction-memory request; held high until IMAck.
REQ-011 IMAddr  out  32  registered fetch address; stable while IMReq=1.
REQ-012 IMAck  in  1  memory response strobe; may assert in the same cycle IMReq first rises.
REQ-013 IMRdata  in  32  instruction word, valid when IMAck=1.
REQ-014 IFIDIns / IFIDPC / IFIDPCPLUS4  out  32 each  IF/ID register contents.
REQ-015 IFIDValid  out  1  IF/ID holds a real instruction.
REQ-016 IFIDFault  out  1  IF/ID holds a misaligned-fetch marker.
REQ-017 FetchBusy  out  1  high when no instruction is available for IF/ID this cycle.

Function
REQ-018 States: FETCH (request outstanding for PC), HOLD (word buffered, IF/ID blocked), DROP (stale request outstanding), FAULT (misaligned PC, no request).
REQ-019 FETCH: IMReq=1, IMAddr=PC; on IMAck with IFIDWr=1 and no IFIDRst, IF/ID loads {IMRdata, PC, PC+4}, IFIDValid=1, PC<=PC+4 when PCWr=1, stay FETCH.
REQ-020 FETCH, IMAck with IFIDWr=0: word and PC captured in hold buffer, PC unchanged, go HOLD.
REQ-021 HOLD: IMReq=0, FetchBusy=0; when IFIDWr=1 buffer loads IF/ID, PC<=PC+4, go FETCH.
REQ-022 No word available (FETCH without IMAck, DROP, FAULT) and IFIDWr=1: IF/ID loads NOP_INS, IFIDValid=0, FetchBusy=1.
REQ-023 Redirect = NPCSel & PCWr; NPCSel with PCWr=0 is ignored.
REQ-024 Redirect in FETCH without IMAck: PC<=NPC, go DROP; IMReq stays high with old IMAddr.
REQ-025 Redirect in FETCH with IMAck, or in HOLD: returned or buffered word discarded, PC<=NPC, go FETCH.
REQ-026 DROP: on IMAck the data is discarded and the FSM goes to FETCH; a further redirect in DROP only updates PC.
REQ-027 IFIDRst has priority over IFIDWr and any load; IFIDRst and redirect in the same cycle both take effect.
REQ-028 PC+4 wraps modulo 2^32.
REQ-029 IMAddr loads from PC on every entry to FETCH.
REQ-030 Throughput is one instruction per cycle with a zero-wait memory; latency from IMAck to IF/ID output is 1 cycle.

Reset
REQ-031 While rst=0: PC=RESET_PC, IMAddr=RESET_PC, state FETCH, IMReq=0, IF/ID = {NOP_INS, 0, 0}, IFIDValid=0, IFIDFault=0, hold buffer cleared.
REQ-032 Reset mid-request abandons the request; memory drops any outstanding request when IMReq falls.
REQ-033 The first request is issued (IMReq=1, IMAddr=RESET_PC) in the cycle after rst returns high.

Configuration
REQ-034 Macro FETCH_ALIGN_CHK_EN defined: on entry to FETCH with PC[1:0]!=0, the FSM goes to FAULT instead of requesting.
REQ-035 FAULT behaviour: IMReq=0; the next IF/ID load is NOP_INS with IFIDValid=1 and IFIDFault=1, after which bubbles are loaded until a redirect returns to FETCH.
REQ-036 Macro undefined: no alignment check, FAULT state absent, IFIDFault tied 0, IMAddr carries PC[1:0] unchanged.

Verification
REQ-037 Zero-wait memory, IMAck=1 every cycle after reset -> IFIDPC = 3000, 3004, 3008 on consecutive cycles, IFIDValid=1.
REQ-038 IMAck delayed 2 cycles -> two bubbles (IFIDValid=0, FetchBusy=1), then the instruction appears; IMAddr is stable throughout.
REQ-039 IMAck arrives while IFIDWr=0 and PCWr=0 for 3 cycles -> HOLD, IMReq=0, IF/ID unchanged; the word loads the cycle after IFIDWr=1.
REQ-040 Redirect to 0x3100 while a request for 0x3008 is outstanding -> DROP; the 0x3008 data is discarded; the next IMAddr is 0x3100.
REQ-041 IFIDRst=1 with NPCSel=1, NPC=0x3200 -> IF/ID = NOP with IFIDValid=0; the next fetch is at 0x3200.
REQ-042 With FETCH_ALIGN_CHK_EN, redirect to 0x3102 -> no IMReq; IFIDFault=1 for one load; a later redirect to 0x3104 resumes fetching.
